// File: rtl/axis_demux_pkg.sv
// Shared types and constants for the packet-steering stream demux.
// Holds the route FSM states, the port indices and the default data width.
package axis_demux_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;

  localparam int unsigned PORT1 = 0;
  localparam int unsigned PORT2 = 1;

  typedef enum logic {
    StIdle,
    StPkt
  } route_state_e;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry output stage: a registered output slot backed by one skid slot.
// in_ready is registered and deasserts only while the skid slot is occupied.
module axis_skid_buf #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_push,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [DATA_W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic              out_last_q, out_last_d, skid_last_q, skid_last_d;
  logic              out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic              in_ready_q;
  logic              pop;

  assign pop = out_valid_q && out_ready;

  always_comb begin
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_valid_d = skid_valid_q;

    if (pop) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    // A push only lands in the output slot if that slot is truly free this cycle.
    if (in_push) begin
      if (!out_valid_q || (pop && !skid_valid_q)) begin
        out_data_d  = in_data;
        out_last_d  = in_last;
        out_valid_d = 1'b1;
      end else begin
        skid_data_d  = in_data;
        skid_last_d  = in_last;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: rtl/axis_demux.sv
// 1:2 stream demux steering whole packets by sel sampled at each packet's first beat.
// Each output port sits behind its own skid buffer; packets per port are counted.
module axis_demux
  import axis_demux_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  output logic [DATA_W-1:0] m_data_1,
  output logic [DATA_W-1:0] m_data_2,
  output logic              m_valid_1,
  output logic              m_valid_2,
  input  logic              m_ready_1,
  input  logic              m_ready_2,
  output logic              m_last_1,
  output logic              m_last_2,
  output logic [CNT_W-1:0]  pkt_cnt_1,
  output logic [CNT_W-1:0]  pkt_cnt_2
);

  route_state_e     state_q, state_d;
  logic             dest_q, dest_d;
  logic             rdy_en_q;
  logic             port_sel;
  logic             accept;
  logic [1:0]       in_ready;
  logic [1:0]       push;
  logic [CNT_W-1:0] pkt_cnt_1_q, pkt_cnt_2_q;

  // sel only steers while no packet is open; afterwards dest is locked in.
  assign port_sel = (state_q == StIdle) ? sel : dest_q;
  assign s_ready  = rdy_en_q && in_ready[port_sel];
  assign accept   = s_valid && s_ready;

  assign push[PORT1] = accept && (port_sel == 1'(PORT1));
  assign push[PORT2] = accept && (port_sel == 1'(PORT2));

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    unique case (state_q)
      StIdle: begin
        if (accept && !s_last) begin
          state_d = StPkt;
          dest_d  = sel;
        end
      end
      StPkt: begin
        if (accept && s_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      dest_q      <= 1'b0;
      rdy_en_q    <= 1'b0;
      pkt_cnt_1_q <= '0;
      pkt_cnt_2_q <= '0;
    end else begin
      state_q  <= state_d;
      dest_q   <= dest_d;
      rdy_en_q <= 1'b1;
      if (push[PORT1] && s_last) pkt_cnt_1_q <= pkt_cnt_1_q + CNT_W'(1);
      if (push[PORT2] && s_last) pkt_cnt_2_q <= pkt_cnt_2_q + CNT_W'(1);
    end
  end

  assign pkt_cnt_1 = pkt_cnt_1_q;
  assign pkt_cnt_2 = pkt_cnt_2_q;

  axis_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid_1 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (s_data),
    .in_last   (s_last),
    .in_push   (push[PORT1]),
    .in_ready  (in_ready[PORT1]),
    .out_data  (m_data_1),
    .out_last  (m_last_1),
    .out_valid (m_valid_1),
    .out_ready (m_ready_1)
  );

  axis_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid_2 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (s_data),
    .in_last   (s_last),
    .in_push   (push[PORT2]),
    .in_ready  (in_ready[PORT2]),
    .out_data  (m_data_2),
    .out_last  (m_last_2),
    .out_valid (m_valid_2),
    .out_ready (m_ready_2)
  );

endmodule

// File: tb/tb_axis_demux.sv
// Directed bench for axis_demux: routing, back-pressure, reset and counter wrap.
// Delivered beats are logged per port and compared against hand-written sequences.
module tb_axis_demux;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  logic              clk;
  logic              reset;
  logic              sel;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              s_last;
  logic [DATA_W-1:0] m_data_1, m_data_2;
  logic              m_valid_1, m_valid_2;
  logic              m_ready_1, m_ready_2;
  logic              m_last_1, m_last_2;
  logic [CNT_W-1:0]  pkt_cnt_1, pkt_cnt_2;

  int vectors = 0;
  int errors  = 0;

  logic [DATA_W:0] q1[$];
  logic [DATA_W:0] q2[$];

  axis_demux #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_last    (s_last),
    .m_data_1  (m_data_1),
    .m_data_2  (m_data_2),
    .m_valid_1 (m_valid_1),
    .m_valid_2 (m_valid_2),
    .m_ready_1 (m_ready_1),
    .m_ready_2 (m_ready_2),
    .m_last_1  (m_last_1),
    .m_last_2  (m_last_2),
    .pkt_cnt_1 (pkt_cnt_1),
    .pkt_cnt_2 (pkt_cnt_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_valid_1 && m_ready_1) q1.push_back({m_last_1, m_data_1});
    if (m_valid_2 && m_ready_2) q2.push_back({m_last_2, m_data_2});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    q1.delete();
    q2.delete();
  endtask

  // Presents one beat and holds it until accepted (bounded).
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic l, input logic sl);
    bit done = 0;
    s_data  = d;
    s_last  = l;
    sel     = sl;
    s_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (s_ready) done = 1;
      tick();
    end
    vectors++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout data=%02h: s_ready stayed 0, required 1", d);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    s_valid   = 1'b1;
    s_data    = 8'h5A;
    s_last    = 1'b1;
    sel       = 1'b0;
    m_ready_1 = 1'b1;
    m_ready_2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (s_ready !== 1'b0 || m_valid_1 !== 1'b0 || m_valid_2 !== 1'b0 ||
          pkt_cnt_1 !== '0 || pkt_cnt_2 !== '0 || m_data_1 !== '0 || m_last_1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: rdy=%b v1=%b v2=%b c1=%0d c2=%0d d1=%02h l1=%b, required all 0",
                 i, s_ready, m_valid_1, m_valid_2, pkt_cnt_1, pkt_cnt_2, m_data_1, m_last_1);
      end
    end
    reset = 1'b0;
    vectors++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_rel_cyc1: s_ready=%b, required 0", s_ready);
    end
    tick();
    vectors++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rel_cyc2: s_ready=%b, required 1", s_ready);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_mid_packet_sel();
    logic [DATA_W:0] exp[4];
    exp = '{9'h011, 9'h012, 9'h013, 9'h114};
    apply_reset();
    m_ready_1 = 1'b1;
    m_ready_2 = 1'b1;
    send_beat(8'h11, 1'b0, 1'b0);
    vectors++;
    if (m_valid_1 !== 1'b1 || m_data_1 !== 8'h11) begin
      errors++;
      $display("FAIL latency_first_beat: v1=%b d1=%02h, required 1 11", m_valid_1, m_data_1);
    end
    send_beat(8'h12, 1'b0, 1'b0);
    send_beat(8'h13, 1'b0, 1'b1);
    send_beat(8'h14, 1'b1, 1'b1);
    s_valid = 1'b0;
    repeat (3) tick();
    vectors++;
    if (q1.size() != 4) begin
      errors++;
      $display("FAIL midpkt_count1: got %0d beats on port 1, required 4", q1.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (q1[i] !== exp[i]) begin
          errors++;
          $display("FAIL midpkt_beat%0d: got %03h, required %03h", i, q1[i], exp[i]);
        end
      end
    end
    vectors++;
    if (q2.size() != 0 || pkt_cnt_1 !== 8'd1 || pkt_cnt_2 !== 8'd0) begin
      errors++;
      $display("FAIL midpkt_counts: q2=%0d c1=%0d c2=%0d, required 0 1 0",
               q2.size(), pkt_cnt_1, pkt_cnt_2);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    m_ready_1 = 1'b1;
    m_ready_2 = 1'b1;
    s_valid = 1'b1; s_last = 1'b1; s_data = 8'hA0; sel = 1'b1;
    vectors++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_rdy0: s_ready=%b, required 1", s_ready);
    end
    tick();
    vectors++;
    if (m_valid_2 !== 1'b1 || m_data_2 !== 8'hA0 || m_last_2 !== 1'b1 || m_valid_1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_a0: v2=%b d2=%02h l2=%b v1=%b, required 1 a0 1 0",
               m_valid_2, m_data_2, m_last_2, m_valid_1);
    end
    s_data = 8'hA1; sel = 1'b0;
    vectors++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_rdy1: s_ready=%b, required 1", s_ready);
    end
    tick();
    vectors++;
    if (m_valid_1 !== 1'b1 || m_data_1 !== 8'hA1 || m_valid_2 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_a1: v1=%b d1=%02h v2=%b, required 1 a1 0", m_valid_1, m_data_1, m_valid_2);
    end
    s_data = 8'hA2; sel = 1'b1;
    vectors++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_rdy2: s_ready=%b, required 1", s_ready);
    end
    tick();
    s_valid = 1'b0;
    vectors++;
    if (m_valid_2 !== 1'b1 || m_data_2 !== 8'hA2 || m_valid_1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_a2: v2=%b d2=%02h v1=%b, required 1 a2 0", m_valid_2, m_data_2, m_valid_1);
    end
    vectors++;
    if (pkt_cnt_2 !== 8'd2 || pkt_cnt_1 !== 8'd1) begin
      errors++;
      $display("FAIL b2b_counts: c1=%0d c2=%0d, required 1 2", pkt_cnt_1, pkt_cnt_2);
    end
  endtask

  task automatic test_back_pressure();
    logic [DATA_W:0] exp[5];
    exp = '{9'h031, 9'h032, 9'h033, 9'h034, 9'h135};
    apply_reset();
    m_ready_1 = 1'b1;
    m_ready_2 = 1'b0;
    send_beat(8'h31, 1'b0, 1'b1);
    send_beat(8'h32, 1'b0, 1'b1);
    s_data = 8'h33; s_last = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (s_ready !== 1'b0 || m_valid_2 !== 1'b1 || m_data_2 !== 8'h31) begin
        errors++;
        $display("FAIL bp_stall%0d: rdy=%b v2=%b d2=%02h, required 0 1 31",
                 i, s_ready, m_valid_2, m_data_2);
      end
      tick();
    end
    sel = 1'b0;  // mid-packet: must not retarget to the idle port
    vectors++;
    if (s_ready !== 1'b0) begin
      errors++; $display("FAIL bp_sel_ignored: s_ready=%b, required 0", s_ready);
    end
    sel = 1'b1;
    m_ready_2 = 1'b1;
    vectors++;
    if (s_ready !== 1'b0) begin
      errors++; $display("FAIL bp_release_same: s_ready=%b, required 0", s_ready);
    end
    tick();
    vectors++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_next: s_ready=%b, required 1", s_ready);
    end
    send_beat(8'h33, 1'b0, 1'b0);
    send_beat(8'h34, 1'b0, 1'b0);
    send_beat(8'h35, 1'b1, 1'b0);
    s_valid = 1'b0;
    repeat (4) tick();
    vectors++;
    if (q2.size() != 5) begin
      errors++;
      $display("FAIL bp_count: got %0d beats on port 2, required 5", q2.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (q2[i] !== exp[i]) begin
          errors++;
          $display("FAIL bp_beat%0d: got %03h, required %03h", i, q2[i], exp[i]);
        end
      end
    end
    vectors++;
    if (pkt_cnt_2 !== 8'd1 || q1.size() != 0) begin
      errors++;
      $display("FAIL bp_counts: c2=%0d q1=%0d, required 1 0", pkt_cnt_2, q1.size());
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    m_ready_1 = 1'b0;
    m_ready_2 = 1'b1;
    send_beat(8'h41, 1'b0, 1'b0);
    send_beat(8'h42, 1'b0, 1'b0);
    s_valid = 1'b0;
    reset   = 1'b1;
    tick();
    vectors++;
    if (m_valid_1 !== 1'b0 || s_ready !== 1'b0 || m_data_1 !== '0) begin
      errors++;
      $display("FAIL rstmid_clear: v1=%b rdy=%b d1=%02h, required 0 0 00",
               m_valid_1, s_ready, m_data_1);
    end
    reset = 1'b0;
    tick();
    m_ready_1 = 1'b1;
    q1.delete();
    q2.delete();
    send_beat(8'h51, 1'b1, 1'b1);
    s_valid = 1'b0;
    repeat (3) tick();
    vectors++;
    if (q2.size() != 1 || q1.size() != 0) begin
      errors++;
      $display("FAIL rstmid_route: q1=%0d q2=%0d, required 0 1", q1.size(), q2.size());
    end else begin
      vectors++;
      if (q2[0] !== 9'h151) begin
        errors++; $display("FAIL rstmid_beat: got %03h, required 151", q2[0]);
      end
    end
    vectors++;
    if (pkt_cnt_1 !== 8'd0 || pkt_cnt_2 !== 8'd1) begin
      errors++;
      $display("FAIL rstmid_counts: c1=%0d c2=%0d, required 0 1", pkt_cnt_1, pkt_cnt_2);
    end
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    m_ready_1 = 1'b1;
    m_ready_2 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send_beat(8'(i), 1'b1, 1'b0);
      if (i == 254) begin
        vectors++;
        if (pkt_cnt_1 !== 8'd255) begin
          errors++; $display("FAIL wrap_255: pkt_cnt_1=%0d, required 255", pkt_cnt_1);
        end
      end
    end
    s_valid = 1'b0;
    vectors++;
    if (pkt_cnt_1 !== 8'd0 || pkt_cnt_2 !== 8'd0) begin
      errors++;
      $display("FAIL wrap_0: c1=%0d c2=%0d, required 0 0", pkt_cnt_1, pkt_cnt_2);
    end
    tick();
    vectors++;
    if (q1.size() != 256) begin
      errors++; $display("FAIL wrap_beats: got %0d beats, required 256", q1.size());
    end
  endtask

  initial begin
    reset     = 1'b1;
    sel       = 1'b0;
    s_data    = '0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    m_ready_1 = 1'b1;
    m_ready_2 = 1'b1;
    test_reset();
    test_mid_packet_sel();
    test_back_to_back();
    test_back_pressure();
    test_reset_mid_packet();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
